// File: rtl/seg_wr_arb_pkg.sv
// Shared constants and encodings for the segment-register write arbiter.
// The segment index encoding is also used by the decoder.
package seg_wr_arb_pkg;

    localparam int SEG_CNT   = 8;
    localparam int SEG_W     = 16;
    localparam int SEG_IDX_W = 3;
    localparam int CNT_W     = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

    typedef enum logic [SEG_IDX_W-1:0] {
        ES = 3'd0,
        CS = 3'd1,
        SS = 3'd2,
        DS = 3'd3,
        FS = 3'd4,
        GS = 3'd5
    } seg_idx_e;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/seg_pend_cnt.sv
// Saturating 2-bit pending-write counter for one segment register.
// Simultaneous inc and dec cancel; dec at zero is ignored.
module seg_pend_cnt
    import seg_wr_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (inc && !dec && count != CNT_MAX) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/seg_wr_arb.sv
// Round-robin arbiter for two segment-register write sources with a registered
// write port and a per-register pending-write scoreboard.
module seg_wr_arb
    import seg_wr_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 a_valid,
    input  logic [SEG_IDX_W-1:0] a_reg,
    input  logic [SEG_W-1:0]     a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [SEG_IDX_W-1:0] b_reg,
    input  logic [SEG_W-1:0]     b_data,
    output logic                 b_ready,
    input  logic                 alloc_valid,
    input  logic [SEG_IDX_W-1:0] alloc_reg,
    output logic                 alloc_ready,
    input  logic                 rd_valid,
    input  logic [SEG_IDX_W-1:0] rd_seg1,
    input  logic [SEG_IDX_W-1:0] rd_seg2,
    output logic                 rd_stall,
    output logic [SEG_CNT-1:0]   busy,
    output logic                 wr_en,
    output logic [SEG_IDX_W-1:0] wr_reg,
    output logic [SEG_W-1:0]     wr_data
);

    grant_e             last_grant;
    logic               grant_a;
    logic               grant_b;
    logic               dec_alloc;
    logic [CNT_W-1:0]   cnt [SEG_CNT];
    logic [SEG_CNT-1:0] inc;
    logic [SEG_CNT-1:0] dec;

    // A wins a tie only when B took the previous grant; nothing is granted in reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            if (a_valid && (!b_valid || last_grant == GRANT_B)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= GRANT_B;
        end else if (grant_a) begin
            last_grant <= GRANT_A;
        end else if (grant_b) begin
            last_grant <= GRANT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= grant_a || grant_b;
            if (grant_a) begin
                wr_reg  <= a_reg;
                wr_data <= a_data;
            end else if (grant_b) begin
                wr_reg  <= b_reg;
                wr_data <= b_data;
            end
        end
    end

    // A full counter can still take an alloc when its pending write commits this cycle.
    assign dec_alloc   = wr_en && (wr_reg == alloc_reg);
    assign alloc_ready = rst_n && !((cnt[alloc_reg] == CNT_MAX) && !dec_alloc);

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < SEG_CNT; i++) begin
            inc[i] = alloc_valid && alloc_ready && (alloc_reg == SEG_IDX_W'(i));
            dec[i] = wr_en && (wr_reg == SEG_IDX_W'(i));
        end
    end

    for (genvar i = 0; i < SEG_CNT; i++) begin : g_cnt
        seg_pend_cnt u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc[i]),
            .dec   (dec[i]),
            .clr   (flush),
            .count (cnt[i])
        );
        assign busy[i] = (cnt[i] != '0);
    end

    assign rd_stall = rd_valid && (busy[rd_seg1] || busy[rd_seg2]);

endmodule

// File: tb/tb_seg_wr_arb.sv
// Self-checking bench for seg_wr_arb: directed scenarios plus randomized traffic
// compared against an abstract model of grants, write port and pending counts.
module tb_seg_wr_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        a_valid;
    logic [2:0]  a_reg;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [2:0]  b_reg;
    logic [15:0] b_data;
    logic        b_ready;
    logic        alloc_valid;
    logic [2:0]  alloc_reg;
    logic        alloc_ready;
    logic        rd_valid;
    logic [2:0]  rd_seg1;
    logic [2:0]  rd_seg2;
    logic        rd_stall;
    logic [7:0]  busy;
    logic        wr_en;
    logic [2:0]  wr_reg;
    logic [15:0] wr_data;

    int checks = 0;
    int errors = 0;

    // Model state: pending counts as plain integers, who won last, and the write port.
    int          m_cnt [8];
    bit          m_last_b;
    bit          m_wr_en;
    logic [2:0]  m_wr_reg;
    logic [15:0] m_wr_data;

    seg_wr_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .a_valid     (a_valid),
        .a_reg       (a_reg),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_reg       (b_reg),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .alloc_valid (alloc_valid),
        .alloc_reg   (alloc_reg),
        .alloc_ready (alloc_ready),
        .rd_valid    (rd_valid),
        .rd_seg1     (rd_seg1),
        .rd_seg2     (rd_seg2),
        .rd_stall    (rd_stall),
        .busy        (busy),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic exp_a_ready();
        return rst_n && a_valid && (!b_valid || m_last_b);
    endfunction

    function automatic logic exp_b_ready();
        return rst_n && b_valid && (!a_valid || !m_last_b);
    endfunction

    function automatic logic exp_alloc_ready();
        return rst_n && !(m_cnt[alloc_reg] == 3 && !(m_wr_en && m_wr_reg == alloc_reg));
    endfunction

    function automatic logic [7:0] exp_busy();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    function automatic logic exp_rd_stall();
        logic [7:0] b;
        b = exp_busy();
        return rd_valid && (b[rd_seg1] || b[rd_seg2]);
    endfunction

    task automatic set_idle();
        flush = 1'b0; a_valid = 1'b0; b_valid = 1'b0; alloc_valid = 1'b0; rd_valid = 1'b0;
    endtask

    // Advance one clock, moving the model with the inputs seen at that edge.
    task automatic cycle();
        logic ga, gb, ar;
        int   nc [8];
        int   d;
        ga = exp_a_ready();
        gb = exp_b_ready();
        ar = exp_alloc_ready();
        for (int i = 0; i < 8; i++) begin
            if (!rst_n || flush) begin
                nc[i] = 0;
            end else begin
                d = ((alloc_valid && ar && alloc_reg == 3'(i)) ? 1 : 0)
                  - ((m_wr_en && m_wr_reg == 3'(i)) ? 1 : 0);
                nc[i] = m_cnt[i] + d;
                if (nc[i] < 0) nc[i] = 0;
                if (nc[i] > 3) nc[i] = 3;
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_wr_en = 1'b0; m_wr_reg = '0; m_wr_data = '0; m_last_b = 1'b1;
        end else begin
            m_wr_en = ga || gb;
            if (ga) begin
                m_wr_reg = a_reg; m_wr_data = a_data; m_last_b = 1'b0;
            end else if (gb) begin
                m_wr_reg = b_reg; m_wr_data = b_data; m_last_b = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) m_cnt[i] = nc[i];
        #1;
    endtask

    task automatic do_flush();
        set_idle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic do_alloc(input logic [2:0] r);
        alloc_valid = 1'b1; alloc_reg = r;
        cycle();
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; a_reg = 3'd6; a_data = 16'h5555; alloc_valid = 1'b1; alloc_reg = 3'd1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++; if (a_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_ready: got %0b expected 0", a_ready); end
            checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %0b expected 0", wr_en); end
            checks++; if (busy !== 8'h00) begin errors++; $display("[TB] FAIL reset_busy: got %02h expected 00", busy); end
            checks++; if (alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_alloc_ready: got %0b expected 0", alloc_ready); end
        end
        checks++; if (wr_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wr_data: got %04h expected 0000", wr_data); end
        set_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        a_valid = 1'b1; a_reg = 3'd3; a_data = 16'h1234;
        b_valid = 1'b1; b_reg = 3'd1; b_data = 16'hF000;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL rr_c0_a_ready: got %0b expected 1", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("[TB] FAIL rr_c0_b_ready: got %0b expected 0", b_ready); end
        cycle();
        checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL rr_c1_wr_en: got %0b expected 1", wr_en); end
        checks++; if (wr_reg !== 3'd3) begin errors++; $display("[TB] FAIL rr_c1_wr_reg: got %0d expected 3", wr_reg); end
        checks++; if (wr_data !== 16'h1234) begin errors++; $display("[TB] FAIL rr_c1_wr_data: got %04h expected 1234", wr_data); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("[TB] FAIL rr_c1_b_ready: got %0b expected 1", b_ready); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("[TB] FAIL rr_c1_a_ready: got %0b expected 0", a_ready); end
        cycle();
        set_idle();
        checks++; if (wr_reg !== 3'd1) begin errors++; $display("[TB] FAIL rr_c2_wr_reg: got %0d expected 1", wr_reg); end
        checks++; if (wr_data !== 16'hF000) begin errors++; $display("[TB] FAIL rr_c2_wr_data: got %04h expected f000", wr_data); end
        cycle();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle_wr_en: got %0b expected 0", wr_en); end
        checks++; if (wr_data !== 16'hF000) begin errors++; $display("[TB] FAIL rr_hold_wr_data: got %04h expected f000", wr_data); end
    endtask

    task automatic test_saturation();
        do_flush();
        for (int k = 0; k < 3; k++) begin
            alloc_valid = 1'b1; alloc_reg = 3'd2; #1;
            checks++; if (alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL sat_alloc_ready_%0d: got %0b expected 1", k, alloc_ready); end
            cycle();
        end
        checks++; if (busy[2] !== 1'b1) begin errors++; $display("[TB] FAIL sat_busy2: got %0b expected 1", busy[2]); end
        #1;
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL sat_4th_alloc_ready: got %0b expected 0", alloc_ready); end
        cycle();
        alloc_valid = 1'b0;
        checks++; if (dut.cnt[2] !== 2'd3) begin errors++; $display("[TB] FAIL sat_hold3: got %0d expected 3", dut.cnt[2]); end
        a_valid = 1'b1; a_reg = 3'd2; a_data = 16'hCAFE;
        cycle();
        a_valid = 1'b0;
        checks++; if (wr_en !== 1'b1 || wr_reg !== 3'd2) begin errors++; $display("[TB] FAIL sat_wr: got en=%0b reg=%0d expected en=1 reg=2", wr_en, wr_reg); end
        alloc_reg = 3'd2; #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL sat_ready_on_commit: got %0b expected 1", alloc_ready); end
        cycle();
        checks++; if (dut.cnt[2] !== 2'd2) begin errors++; $display("[TB] FAIL sat_after_write: got %0d expected 2", dut.cnt[2]); end
    endtask

    task automatic test_simultaneous();
        do_flush();
        do_alloc(3'd5);
        a_valid = 1'b1; a_reg = 3'd5; a_data = 16'h0A05;
        cycle();
        a_valid = 1'b0;
        alloc_valid = 1'b1; alloc_reg = 3'd5;
        cycle();
        alloc_valid = 1'b0;
        checks++; if (dut.cnt[5] !== 2'd1) begin errors++; $display("[TB] FAIL sim_count5: got %0d expected 1", dut.cnt[5]); end
        checks++; if (busy[5] !== 1'b1) begin errors++; $display("[TB] FAIL sim_busy5: got %0b expected 1", busy[5]); end
    endtask

    task automatic test_flush();
        do_flush();
        do_alloc(3'd0);
        do_alloc(3'd0);
        do_alloc(3'd4);
        checks++; if (busy !== 8'h11) begin errors++; $display("[TB] FAIL fl_pre_busy: got %02h expected 11", busy); end
        flush = 1'b1; a_valid = 1'b1; a_reg = 3'd4; a_data = 16'hBEEF; alloc_valid = 1'b1; alloc_reg = 3'd6;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL fl_a_ready: got %0b expected 1", a_ready); end
        cycle();
        set_idle();
        checks++; if (busy !== 8'h00) begin errors++; $display("[TB] FAIL fl_busy: got %02h expected 00", busy); end
        checks++; if (wr_en !== 1'b1 || wr_reg !== 3'd4) begin errors++; $display("[TB] FAIL fl_commit: got en=%0b reg=%0d expected en=1 reg=4", wr_en, wr_reg); end
        cycle();
        checks++; if (dut.cnt[4] !== 2'd0) begin errors++; $display("[TB] FAIL fl_no_underflow: got %0d expected 0", dut.cnt[4]); end
        checks++; if (busy !== 8'h00) begin errors++; $display("[TB] FAIL fl_busy_after: got %02h expected 00", busy); end
    endtask

    task automatic test_stall();
        do_flush();
        do_alloc(3'd3);
        rd_valid = 1'b1; rd_seg1 = 3'd0; rd_seg2 = 3'd3; #1;
        checks++; if (busy[3] !== 1'b1) begin errors++; $display("[TB] FAIL st_busy3: got %0b expected 1", busy[3]); end
        checks++; if (rd_stall !== 1'b1) begin errors++; $display("[TB] FAIL st_seg2: got %0b expected 1", rd_stall); end
        rd_seg1 = 3'd3; rd_seg2 = 3'd0; #1;
        checks++; if (rd_stall !== 1'b1) begin errors++; $display("[TB] FAIL st_seg1: got %0b expected 1", rd_stall); end
        rd_seg1 = 3'd1; rd_seg2 = 3'd2; #1;
        checks++; if (rd_stall !== 1'b0) begin errors++; $display("[TB] FAIL st_clean: got %0b expected 0", rd_stall); end
        rd_seg1 = 3'd0; rd_seg2 = 3'd3; rd_valid = 1'b0; #1;
        checks++; if (rd_stall !== 1'b0) begin errors++; $display("[TB] FAIL st_no_valid: got %0b expected 0", rd_stall); end
    endtask

    task automatic test_reset_drop();
        set_idle();
        a_valid = 1'b1; a_reg = 3'd6; a_data = 16'h6666;
        cycle();
        checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL rd_pre_wr_en: got %0b expected 1", wr_en); end
        rst_n = 1'b0; #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("[TB] FAIL rd_a_ready: got %0b expected 0", a_ready); end
        cycle();
        checks++; if (wr_en !== 1'b0 || wr_reg !== 3'd0 || wr_data !== 16'h0) begin errors++; $display("[TB] FAIL rd_dropped: got en=%0b reg=%0d data=%04h expected 0/0/0000", wr_en, wr_reg, wr_data); end
        rst_n = 1'b1; b_valid = 1'b1; b_reg = 3'd2; #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("[TB] FAIL rd_tie_after_reset: got a=%0b b=%0b expected a=1 b=0", a_ready, b_ready); end
        cycle();
        set_idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n       = ($urandom_range(0, 49) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            a_valid     = $urandom_range(0, 1);
            a_reg       = 3'($urandom_range(0, 7));
            a_data      = 16'($urandom);
            b_valid     = $urandom_range(0, 1);
            b_reg       = 3'($urandom_range(0, 7));
            b_data      = 16'($urandom);
            alloc_valid = ($urandom_range(0, 3) != 0);
            alloc_reg   = 3'($urandom_range(0, 7));
            rd_valid    = $urandom_range(0, 1);
            rd_seg1     = 3'($urandom_range(0, 7));
            rd_seg2     = 3'($urandom_range(0, 7));
            #1;
            checks++; if (a_ready !== exp_a_ready()) begin errors++; $display("[TB] FAIL rnd_a_ready@%0d: got %0b expected %0b", n, a_ready, exp_a_ready()); end
            checks++; if (b_ready !== exp_b_ready()) begin errors++; $display("[TB] FAIL rnd_b_ready@%0d: got %0b expected %0b", n, b_ready, exp_b_ready()); end
            checks++; if (alloc_ready !== exp_alloc_ready()) begin errors++; $display("[TB] FAIL rnd_alloc_ready@%0d: got %0b expected %0b", n, alloc_ready, exp_alloc_ready()); end
            checks++; if (rd_stall !== exp_rd_stall()) begin errors++; $display("[TB] FAIL rnd_rd_stall@%0d: got %0b expected %0b", n, rd_stall, exp_rd_stall()); end
            cycle();
            checks++; if (wr_en !== m_wr_en) begin errors++; $display("[TB] FAIL rnd_wr_en@%0d: got %0b expected %0b", n, wr_en, m_wr_en); end
            checks++; if (wr_reg !== m_wr_reg || wr_data !== m_wr_data) begin errors++; $display("[TB] FAIL rnd_wr_port@%0d: got %0d/%04h expected %0d/%04h", n, wr_reg, wr_data, m_wr_reg, m_wr_data); end
            checks++; if (busy !== exp_busy()) begin errors++; $display("[TB] FAIL rnd_busy@%0d: got %02h expected %02h", n, busy, exp_busy()); end
        end
        rst_n = 1'b1;
        set_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        a_reg = '0; a_data = '0; b_reg = '0; b_data = '0;
        alloc_reg = '0; rd_seg1 = '0; rd_seg2 = '0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_last_b = 1'b1; m_wr_en = 1'b0; m_wr_reg = '0; m_wr_data = '0;
        #1;
        test_reset();
        test_round_robin();
        test_saturation();
        test_simultaneous();
        test_flush();
        test_stall();
        test_reset_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
